// File: rtl/vote_display_pkg.sv
// vote_display_pkg: shared class count, FSM states and seven-segment lookup
package vote_display_pkg;
  localparam int NUM_CLASSES = 10;
  typedef enum logic [1:0] {COLLECT, DECIDE, PUBLISH} state_t;
  localparam logic [6:0] SEG_LUT [NUM_CLASSES] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-high gfedcba segments for a digit, blank when disabled
module seg7_decode
  import vote_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       enable,
  output logic [6:0] seg
);
  // blank for disabled display or non-digit codes
  always_comb seg = (enable && digit < 4'(NUM_CLASSES)) ? SEG_LUT[digit] : '0;
endmodule

// File: rtl/vote_display.sv
// vote_display: majority vote over a window of classifications, shown on seven segments
module vote_display
  import vote_display_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int THRESH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] class_in,
  input  logic       class_valid,
  output logic       class_ready,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic [6:0] seg,
  output logic       result_strobe
);
  state_t     state_q, state_d;
  logic [3:0] cnt [NUM_CLASSES];
  logic [3:0] inv_cnt, count, idx, max_cnt, max_idx, win_cnt, win_idx;
  logic       full, accept, gt, last;
  // handshake, scan comparison and next state
  always_comb begin
    full          = count == 4'(WINDOW);
    class_ready   = state_q == COLLECT && !full;
    accept        = class_ready && class_valid;
    result_strobe = state_q == PUBLISH;
    gt            = cnt[idx] > max_cnt;
    win_cnt       = gt ? cnt[idx] : max_cnt;
    win_idx       = gt ? idx : max_idx;
    last          = idx == 4'(NUM_CLASSES - 1);
    state_d       = (state_q == COLLECT && full) ? DECIDE :
                    (state_q == DECIDE && last)  ? PUBLISH :
                    (state_q == PUBLISH)         ? COLLECT : state_q;
  end
  // state register
  always_ff @(posedge clk) state_q <= rst ? COLLECT : state_d;
  // counters, running maximum and published result
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      inv_cnt     <= '0;
      count       <= '0;
      idx         <= '0;
      max_cnt     <= '0;
      max_idx     <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
    end else begin
      if (accept) begin
        count <= count + 4'd1;
        if (class_in < 4'(NUM_CLASSES)) cnt[class_in] <= cnt[class_in] + 4'd1;
        else inv_cnt <= inv_cnt + 4'd1;
      end
      if (state_q == COLLECT) begin
        idx     <= '0;
        max_cnt <= '0;
        max_idx <= '0;
      end
      if (state_q == DECIDE) begin
        idx     <= idx + 4'd1;
        max_cnt <= win_cnt;
        max_idx <= win_idx;
        if (last) begin
          digit       <= win_idx;
          digit_valid <= win_cnt >= 4'(THRESH);
        end
      end
      if (state_q == PUBLISH) begin
        for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
        inv_cnt <= '0;
        count   <= '0;
      end
    end
  end
  seg7_decode u_seg (.digit(digit), .enable(digit_valid), .seg(seg));
endmodule
